imem_loader: RTL

- Writer side of the instruction memory: streams a program image into a writable 64-word instruction RAM before the single-cycle MIPS core fetches from it.
- Accepts bytes over a valid/ready stream and packs them big-endian into 32-bit words.
- Issues one RAM write per word at consecutive word addresses from 0.
- Holds the core (`cpu_hold`) while loading and reports completion and error status.

---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader,
// the instruction RAM and the fetch path.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DEPTH  = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler for the imem loader.
// First byte of a word ends up in bits [31:24].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  in_data,
    output logic [31:0] data,
    output logic [1:0]  idx,
    output logic        word_full
);

    assign word_full = accept && (idx == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            idx  <= '0;
        end else if (clear) begin
            data <= '0;
            idx  <= '0;
        end else if (accept) begin
            data <= {data[23:0], in_data};
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program image into the instruction RAM,
// holding the core until the load completes or fails.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_partial,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [1:0]        idx;
    logic              accept;
    logic              kick;
    logic              word_full;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign kick     = start && (state != LOAD);

    // The final write cycle sits in DONE, so hold stays up through it.
    assign busy     = in_ready || imem_we;
    assign cpu_hold = busy;

    byte_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .accept    (accept),
        .clear     (kick),
        .in_data   (in_data),
        .data      (imem_wdata),
        .idx       (idx),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wptr         <= '0;
            word_count   <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            done         <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    if (word_full) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= wptr;
                        word_count <= word_count + CNT_ONE;
                        if (wptr != LAST_ADDR)
                            wptr <= wptr + PTR_ONE;
                        if (in_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (wptr == LAST_ADDR) begin
                            err_overflow <= 1'b1;
                            done         <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (accept && in_last && (idx != 2'd3)) begin
                        err_partial <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        done         <= 1'b0;
                        err_partial  <= 1'b0;
                        err_overflow <= 1'b0;
                        word_count   <= '0;
                        wptr         <= '0;
                        state        <= LOAD;
                    end
                end
            endcase
        end
    end

endmodule
